// File: rtl/bgsub_controller.sv
// Frame sequencer for background subtraction: captures a reference frame, then streams RUN frames.
// Optional periodic reference recapture is enabled by defining BGSUB_REF_REFRESH_EN.
module bgsub_controller #(
   parameter int H_PIXELS       = 160,
   parameter int V_LINES        = 120,
   parameter int ADDR_W         = 15,
   parameter int REFRESH_FRAMES = 64
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              vsync,
   input  logic              href,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              ref_we,
   output logic              acc_en,
   output logic              acc_clr,
   output logic              frame_done,
   output logic              short_frame,
   output logic              busy,
   output logic [7:0]        frame_cnt
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      ARM_REF     = 3'd1,
      CAPTURE_REF = 3'd2,
      ARM_RUN     = 3'd3,
      RUN         = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_PIXELS * V_LINES - 1);

`ifdef BGSUB_REF_REFRESH_EN
   localparam bit REFRESH_ON = 1'b1;
`else
   localparam bit REFRESH_ON = 1'b0;
`endif

   state_t            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              vsync_q;
   logic              stop_q;
   logic              done_q;

   logic       vs_rise;
   logic       last;
   logic       stop_pend;
   logic [7:0] frame_nxt;
   logic       refresh_hit;

   always_comb begin
      vs_rise     = vsync & ~vsync_q;
      last        = (cnt_q == LAST);
      stop_pend   = stop_q | stop;
      frame_nxt   = frame_cnt + 8'd1;
      refresh_hit = REFRESH_ON && ((int'(frame_nxt) % REFRESH_FRAMES) == 0);
   end

   always_ff @(posedge pclk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         vsync_q     <= 1'b0;
         stop_q      <= 1'b0;
         done_q      <= 1'b0;
         pix_addr    <= '0;
         ref_we      <= 1'b0;
         acc_en      <= 1'b0;
         acc_clr     <= 1'b0;
         frame_done  <= 1'b0;
         short_frame <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= 8'd0;
      end else begin
         vsync_q     <= vsync;
         ref_we      <= 1'b0;
         acc_en      <= 1'b0;
         acc_clr     <= 1'b0;
         short_frame <= 1'b0;
         // completion is reported one cycle after the last pixel's enable
         frame_done  <= done_q;
         done_q      <= 1'b0;
         if (done_q)
            frame_cnt <= frame_nxt;

         unique case (state_q)
            IDLE: begin
               stop_q <= 1'b0;
               if (start) begin
                  state_q <= ARM_REF;
                  busy    <= 1'b1;
               end
            end
            ARM_REF: begin
               if (stop) begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end else if (vs_rise) begin
                  state_q <= CAPTURE_REF;
                  cnt_q   <= '0;
               end
            end
            CAPTURE_REF: begin
               if (stop)
                  stop_q <= 1'b1;
               if (href && last) begin
                  pix_addr <= cnt_q;
                  ref_we   <= 1'b1;
                  cnt_q    <= '0;
                  stop_q   <= 1'b0;
                  if (stop_pend) begin
                     state_q <= IDLE;
                     busy    <= 1'b0;
                  end else begin
                     state_q <= ARM_RUN;
                  end
               end else if (vs_rise) begin
                  short_frame <= 1'b1;
                  cnt_q       <= '0;
               end else if (href) begin
                  pix_addr <= cnt_q;
                  ref_we   <= 1'b1;
                  cnt_q    <= cnt_q + ADDR_W'(1);
               end
            end
            ARM_RUN: begin
               if (stop) begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end else if (vs_rise) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
                  acc_clr <= 1'b1;
               end
            end
            RUN: begin
               if (stop)
                  stop_q <= 1'b1;
               if (href && last) begin
                  pix_addr <= cnt_q;
                  acc_en   <= 1'b1;
                  done_q   <= 1'b1;
                  cnt_q    <= '0;
                  stop_q   <= 1'b0;
                  if (stop_pend) begin
                     state_q <= IDLE;
                     busy    <= 1'b0;
                  end else if (refresh_hit) begin
                     state_q <= ARM_REF;
                  end else begin
                     state_q <= ARM_RUN;
                  end
               end else if (vs_rise) begin
                  short_frame <= 1'b1;
                  acc_clr     <= 1'b1;
                  cnt_q       <= '0;
               end else if (href) begin
                  pix_addr <= cnt_q;
                  acc_en   <= 1'b1;
                  cnt_q    <= cnt_q + ADDR_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bgsub_controller.sv
// Directed bench for bgsub_controller with a 4x2 frame and REFRESH_FRAMES=2.
// Expected values are hand-derived per scenario.
module tb_bgsub_controller;

   logic       pclk = 1'b0;
   logic       reset, start, stop, vsync, href;
   logic [3:0] pix_addr;
   logic       ref_we, acc_en, acc_clr, frame_done, short_frame, busy;
   logic [7:0] frame_cnt;

   int tests = 0;
   int fails = 0;

   bgsub_controller #(
      .H_PIXELS(4), .V_LINES(2), .ADDR_W(4), .REFRESH_FRAMES(2)
   ) dut (
      .pclk(pclk), .reset(reset), .start(start), .stop(stop),
      .vsync(vsync), .href(href), .pix_addr(pix_addr),
      .ref_we(ref_we), .acc_en(acc_en), .acc_clr(acc_clr),
      .frame_done(frame_done), .short_frame(short_frame),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 pclk = ~pclk;

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic to_arm_run();
      reset = 1'b0; start = 1'b0; stop = 1'b0; vsync = 1'b0; href = 1'b0;
      tick();
      reset = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      vsync = 1'b1; tick(); vsync = 1'b0;
      for (int i = 0; i < 8; i++) begin
         href = 1'b1; tick();
      end
      href = 1'b0; tick();
   endtask

   task automatic enter_run();
      vsync = 1'b1; tick(); vsync = 1'b0;
   endtask

   task automatic pixels(input int n);
      for (int i = 0; i < n; i++) begin
         href = 1'b1; tick();
      end
      href = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; stop = 1'b0; vsync = 1'b0; href = 1'b0;
      tick();
      tests++;
      if ({pix_addr, ref_we, acc_en, acc_clr, frame_done, short_frame,
           busy, frame_cnt} !== 19'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %0h want 0",
            {pix_addr, ref_we, acc_en, acc_clr, frame_done, short_frame, busy, frame_cnt});
      end
      reset = 1'b1;
   endtask

   task automatic test_capture_and_run();
      int done_seen;
      reset = 1'b0; tick(); reset = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL busy_after_start: got %b want 1", busy);
      end
      vsync = 1'b1; tick(); vsync = 1'b0;
      for (int i = 0; i < 8; i++) begin
         href = 1'b1; tick();
         tests++;
         if (ref_we !== 1'b1 || acc_en !== 1'b0 || pix_addr !== 4'(i)) begin
            fails++;
            $display("FAIL capture_pix%0d: got we=%b en=%b addr=%0d want we=1 en=0 addr=%0d",
               i, ref_we, acc_en, pix_addr, i);
         end
      end
      href = 1'b0;
      tests++;
      if (dut.state_q !== 3'd3) begin
         fails++; $display("FAIL state_arm_run: got %0d want 3", dut.state_q);
      end
      href = 1'b1; tick(); href = 1'b0;
      tests++;
      if (ref_we !== 1'b0 || acc_en !== 1'b0) begin
         fails++; $display("FAIL arm_href: got we=%b en=%b want 0 0", ref_we, acc_en);
      end
      enter_run();
      tests++;
      if (acc_clr !== 1'b1 || acc_en !== 1'b0) begin
         fails++; $display("FAIL acc_clr_entry: got clr=%b en=%b want 1 0", acc_clr, acc_en);
      end
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         href = 1'b1; tick();
         if (frame_done) done_seen++;
         tests++;
         if (acc_en !== 1'b1 || ref_we !== 1'b0 || pix_addr !== 4'(i)) begin
            fails++;
            $display("FAIL run_pix%0d: got en=%b we=%b addr=%0d want en=1 we=0 addr=%0d",
               i, acc_en, ref_we, pix_addr, i);
         end
      end
      href = 1'b0;
      tick();
      if (frame_done) done_seen++;
      tests++;
      if (frame_done !== 1'b1 || frame_cnt !== 8'd1) begin
         fails++; $display("FAIL frame_done: got fd=%b cnt=%0d want 1 1", frame_done, frame_cnt);
      end
      tick();
      if (frame_done) done_seen++;
      tests++;
      if (done_seen != 1 || frame_cnt !== 8'd1) begin
         fails++; $display("FAIL done_once: got %0d pulses cnt=%0d want 1 1", done_seen, frame_cnt);
      end
   endtask

   task automatic test_short_frame();
      to_arm_run();
      enter_run();
      pixels(5);
      vsync = 1'b1; tick(); vsync = 1'b0;
      tests++;
      if (short_frame !== 1'b1 || acc_clr !== 1'b1 || acc_en !== 1'b0) begin
         fails++;
         $display("FAIL short_pulse: got sf=%b clr=%b en=%b want 1 1 0", short_frame, acc_clr, acc_en);
      end
      href = 1'b1; tick();
      tests++;
      if (acc_en !== 1'b1 || pix_addr !== 4'd0 || short_frame !== 1'b0) begin
         fails++;
         $display("FAIL short_restart: got en=%b addr=%0d sf=%b want 1 0 0", acc_en, pix_addr, short_frame);
      end
      pixels(7);
      tick();
      tests++;
      if (frame_done !== 1'b1 || frame_cnt !== 8'd1) begin
         fails++; $display("FAIL short_then_full: got fd=%b cnt=%0d want 1 1", frame_done, frame_cnt);
      end
   endtask

   task automatic test_stop();
      to_arm_run();
      enter_run();
      pixels(3);
      stop = 1'b1; href = 1'b1; tick(); stop = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL stop_latched_busy: got %b want 1", busy);
      end
      pixels(4);
      tests++;
      if (busy !== 1'b0 || acc_en !== 1'b1 || pix_addr !== 4'd7) begin
         fails++;
         $display("FAIL stop_frame_end: got busy=%b en=%b addr=%0d want 0 1 7", busy, acc_en, pix_addr);
      end
      tick();
      tests++;
      if (frame_done !== 1'b1 || frame_cnt !== 8'd1) begin
         fails++; $display("FAIL stop_done: got fd=%b cnt=%0d want 1 1", frame_done, frame_cnt);
      end
      stop = 1'b1; tick(); stop = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL restart_after_stop: got %b want 1", busy);
      end
      to_arm_run();
      stop = 1'b1; tick(); stop = 1'b0;
      tests++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL stop_arm_run: got %b want 0", busy);
      end
      enter_run();
      tests++;
      if (acc_clr !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL idle_ignores_vsync: got clr=%b busy=%b want 0 0", acc_clr, busy);
      end
   endtask

   task automatic test_refresh();
      logic [2:0] exp_state;
`ifdef BGSUB_REF_REFRESH_EN
      exp_state = 3'd1;
`else
      exp_state = 3'd3;
`endif
      to_arm_run();
      enter_run(); pixels(8); tick(); tick();
      tests++;
      if (dut.state_q !== 3'd3 || frame_cnt !== 8'd1) begin
         fails++; $display("FAIL refresh_f1: got st=%0d cnt=%0d want 3 1", dut.state_q, frame_cnt);
      end
      enter_run(); pixels(8); tick(); tick();
      tests++;
      if (dut.state_q !== exp_state || frame_cnt !== 8'd2) begin
         fails++;
         $display("FAIL refresh_f2: got st=%0d cnt=%0d want %0d 2", dut.state_q, frame_cnt, exp_state);
      end
      enter_run();
      href = 1'b1; tick(); href = 1'b0;
      tests++;
      if (ref_we !== (exp_state == 3'd1) || acc_en !== (exp_state == 3'd3)) begin
         fails++;
         $display("FAIL refresh_next: got we=%b en=%b want %b %b",
            ref_we, acc_en, exp_state == 3'd1, exp_state == 3'd3);
      end
   endtask

   task automatic test_coincident();
      to_arm_run();
      enter_run();
      pixels(7);
      href = 1'b1; vsync = 1'b1; tick(); href = 1'b0;
      tests++;
      if (acc_en !== 1'b1 || pix_addr !== 4'd7 || short_frame !== 1'b0) begin
         fails++;
         $display("FAIL coinc_last: got en=%b addr=%0d sf=%b want 1 7 0", acc_en, pix_addr, short_frame);
      end
      tick();
      tests++;
      if (frame_done !== 1'b1 || frame_cnt !== 8'd1 || short_frame !== 1'b0) begin
         fails++;
         $display("FAIL coinc_done: got fd=%b cnt=%0d sf=%b want 1 1 0", frame_done, frame_cnt, short_frame);
      end
      href = 1'b1; tick(); href = 1'b0;
      tests++;
      if (acc_en !== 1'b0 || acc_clr !== 1'b0) begin
         fails++; $display("FAIL coinc_no_run: got en=%b clr=%b want 0 0", acc_en, acc_clr);
      end
      vsync = 1'b0; tick();
      enter_run();
      tests++;
      if (acc_clr !== 1'b1) begin
         fails++; $display("FAIL coinc_next_vsync: got clr=%b want 1", acc_clr);
      end
   endtask

   task automatic test_reset_mid_run();
      to_arm_run();
      enter_run();
      pixels(3);
      href = 1'b1;
      reset = 1'b0; tick(); reset = 1'b1; href = 1'b0;
      tests++;
      if ({pix_addr, ref_we, acc_en, acc_clr, frame_done, short_frame,
           busy, frame_cnt} !== 19'd0 || dut.state_q !== 3'd0) begin
         fails++;
         $display("FAIL reset_mid_run: got %0h st=%0d want 0 0",
            {pix_addr, ref_we, acc_en, acc_clr, frame_done, short_frame, busy, frame_cnt},
            dut.state_q);
      end
   endtask

   initial begin
      test_reset();
      test_capture_and_run();
      test_short_frame();
      test_stop();
      test_refresh();
      test_coincident();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
